// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage: default widths, the access
// timeout, and the access FSM state encoding.
package memory_stage_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ADDR_W  = 11;
  localparam int DEF_REG_AW  = 3;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory access sequencer: owns the state register, the timeout
// counter, the registered dmem_* request signals and upstream stall.
//
// Handshake (dmem_req/dmem_ack): once dmem_req rises, dmem_req, dmem_we,
// dmem_addr and dmem_wdata stay constant until a rising edge samples
// dmem_ack = 1 (transfer complete, dmem_rdata valid in that same cycle) or
// the access times out; dmem_ack seen while no request is open is ignored.
module mem_access_fsm
  import memory_stage_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memop,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] store_data,
  input  logic              dmem_ack,
  output state_t            state,
  output logic              stall,
  output logic              access_done,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              mem_err_r
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;
  logic             last_cnt;

  assign last_cnt    = (cnt == CNT_LAST);
  assign access_done = (state == ACCESS) && dmem_ack;

  // Stall while a memory op waits to start or waits for ack; release on
  // ack and on the final timeout cycle so the faulting op retires.
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = memop;
      ACCESS:  stall = !dmem_ack && !last_cnt;
      default: stall = 1'b0;
    endcase
  end

  // Request sequencing: launch from IDLE, hold in ACCESS until ack or timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      mem_err_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (memop) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write;
            dmem_addr  <= mem_addr;
            dmem_wdata <= store_data;
            cnt        <= '0;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            state    <= IDLE;
          end else if (last_cnt) begin
            dmem_req  <= 1'b0;
            mem_err_r <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: consumes EX/MEM, runs loads/stores through the
// access FSM, and drives the MEM/WB register towards writeback.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int REG_AW  = DEF_REG_AW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              RegWrite,
  input  logic [REG_AW-1:0] reg_write_address_from_execute,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] wb_data_r,
  output logic              RegWrite_r,
  output logic [REG_AW-1:0] reg_write_address_to_writeback,
  output logic              wb_valid_r,
  output logic              mem_err_r
);

  state_t      state;
  logic        memop;
  logic        is_load;
  logic        access_done;
  logic [DATA_W-1:0] wb_next;

  // A store wins when both read and write are set, so no load data is taken.
  assign memop   = ex_valid & (mem_read | mem_write);
  assign is_load = mem_read & ~mem_write;

  mem_access_fsm #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) u_fsm (
    .clk         (clk),
    .rst_n       (reset),
    .memop       (memop),
    .mem_write   (mem_write),
    .mem_addr    (alu_result[ADDR_W-1:0]),
    .store_data  (store_data),
    .dmem_ack    (dmem_ack),
    .state       (state),
    .stall       (stall),
    .access_done (access_done),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .mem_err_r   (mem_err_r)
  );

  // Writeback mux: load data on a completed load, otherwise the ALU result.
  always_comb begin
    wb_next = alu_result;
    if (access_done && is_load) wb_next = dmem_rdata;
  end

  // MEM/WB register: pass-through, completed access, or bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_data_r                      <= '0;
      RegWrite_r                     <= 1'b0;
      reg_write_address_to_writeback <= '0;
      wb_valid_r                     <= 1'b0;
    end else if (state == IDLE && !memop) begin
      wb_data_r                      <= wb_next;
      RegWrite_r                     <= RegWrite & ex_valid;
      reg_write_address_to_writeback <= reg_write_address_from_execute;
      wb_valid_r                     <= ex_valid;
    end else if (access_done) begin
      wb_data_r                      <= wb_next;
      RegWrite_r                     <= RegWrite;
      reg_write_address_to_writeback <= reg_write_address_from_execute;
      wb_valid_r                     <= 1'b1;
    end else begin
      RegWrite_r <= 1'b0;
      wb_valid_r <= 1'b0;
    end
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Consumer end of the EX/MEM pipeline register. Takes the registered ALU result, store data and control bits from execute.
- Performs loads and stores over a req/ack data-memory handshake and stalls upstream while an access is outstanding.
- Drives the MEM/WB pipeline register (writeback data, RegWrite, destination register) towards writeback.

Parameters:
- DATA_W, 16, datapath and memory word width
- ADDR_W, 11, data-memory word-address width; taken from the low bits of alu_result
- REG_AW, 3, register-file address width
- TIMEOUT, 16, maximum cycles in ACCESS without ack before abort; must be >= 2

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 = reset asserted
- ex_valid  in  1  EX/MEM slot holds a real instruction
- alu_result  in  DATA_W  ALU result; memory address for loads/stores
- store_data  in  DATA_W  store operand
- mem_read  in  1  load
- mem_write  in  1  store
- RegWrite  in  1  instruction writes the register file
- reg_write_address_from_execute  in  REG_AW  destination register
- stall  out  1  combinational; upstream must hold EX/MEM contents while 1
- dmem_req  out  1  registered memory request
- dmem_we  out  1  registered; 1 = write
- dmem_addr  out  ADDR_W  registered address
- dmem_wdata  out  DATA_W  registered write data
- dmem_ack  in  1  memory completes the request this cycle
- dmem_rdata  in  DATA_W  read data; valid only when dmem_ack = 1
- wb_data_r  out  DATA_W  MEM/WB data
- RegWrite_r  out  1  MEM/WB write enable
- reg_write_address_to_writeback  out  REG_AW  MEM/WB destination register
- wb_valid_r  out  1  MEM/WB slot valid
- mem_err_r  out  1  sticky timeout flag

Behaviour:
- Reset (reset = 0, asynchronous): every registered output goes to 0, state goes to IDLE, timeout counter goes to 0. This applies mid-access: dmem_req drops immediately; the aborted access gets no writeback.
- memop = ex_valid & (mem_read | mem_write). If both mem_read and mem_write are 1, it is a store; no load data is captured.
- States: IDLE, ACCESS.
- IDLE, memop = 0:
  - Single-cycle pass-through.
  - wb_data_r <= alu_result; RegWrite_r <= RegWrite & ex_valid; address register copied; wb_valid_r <= ex_valid.
  - stall = 0.
- IDLE, memop = 1:
  - stall = 1.
  - Latch dmem_addr <= alu_result[ADDR_W-1:0], dmem_we <= mem_write, dmem_wdata <= store_data.
  - dmem_req <= 1; counter <= 0; go to ACCESS.
  - MEM/WB gets a bubble: wb_valid_r <= 0, RegWrite_r <= 0.
- ACCESS: dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable until the cycle ack is sampled or the access is aborted.
  - If dmem_ack = 0: stall = 1, counter increments, MEM/WB gets a bubble.
  - If dmem_ack = 1: stall = 0.
    - wb_data_r <= dmem_rdata for a load, alu_result for a store.
    - RegWrite_r <= RegWrite; address register copied; wb_valid_r <= 1.
    - dmem_req <= 0; go to IDLE.
- Latency: a non-memory instruction takes 1 cycle. A memory op takes 2 cycles minimum (ack in the first ACCESS cycle), i.e. 1 + number of ACCESS cycles.
- Timeout: in ACCESS with counter = TIMEOUT-1 and dmem_ack = 0:
  - dmem_req <= 0; mem_err_r <= 1 (sticky until reset).
  - MEM/WB gets a bubble; go to IDLE; stall = 0 that cycle so the faulting instruction retires.
  - If ack and timeout land in the same cycle, ack wins and there is no error.
- dmem_ack while in IDLE is ignored.
- Back-to-back memory ops: the cycle after completion is IDLE with the next EX/MEM contents, so the next request starts one cycle later. There is never a request with dmem_req = 0 between the handshakes except for that IDLE cycle.
- Address truncation: alu_result bits above ADDR_W are ignored; no error is raised.

Decomposition:
- Shared include/package holds: state encodings (IDLE = 0, ACCESS = 1), default widths (DATA_W, ADDR_W, REG_AW), and the TIMEOUT default.
- One natural sub-module, mem_access_fsm: state register, timeout counter, dmem_* registers, stall generation.
- The memory_stage top holds the MEM/WB register and the writeback mux.

Test Plan:
- Non-mem pass-through: ex_valid = 1, alu_result = 0x1234, RegWrite = 1, address = 5 -> next edge: wb_data_r = 0x1234, RegWrite_r = 1, reg_write_address_to_writeback = 5, wb_valid_r = 1; stall never asserted.
- Load with immediate ack: mem_read = 1, alu_result = 0x0040 -> cycle 0 stall = 1; cycle 1 dmem_req = 1, dmem_addr = 0x040, dmem_we = 0; ack with rdata = 0xBEEF -> wb_data_r = 0xBEEF, RegWrite_r = 1; dmem_req = 0 next cycle.
- Store with 3-cycle ack delay: mem_write = 1, store_data = 0xA5A5, alu_result = 0x0812 -> dmem_addr = 0x012, dmem_we = 1, dmem_wdata = 0xA5A5 held stable for 3 cycles; stall = 1 for 3 cycles; wb_valid_r = 1 after ack.
- Timeout, TIMEOUT = 4, ack never returned -> dmem_req high exactly 4 cycles, then mem_err_r = 1, wb_valid_r = 0, stall released. Repeat with ack on cycle 4 -> no error, normal writeback.
- Async reset mid-access: reset = 0 during ACCESS, between clock edges -> dmem_req, stall-state and every MEM/WB output are 0 immediately. After release, a fresh load completes normally.
- Back-to-back load then non-mem op, mem_read & mem_write both set -> store behaviour: dmem_we = 1, no rdata captured.
